// File: rtl/mem_word_bridge_if.sv
// Signal bundle between the Core word port, the bridge and the DDR3 controller app_* port.
// The bridge uses the slave view; the surrounding Core/controller environment uses master.
interface mem_word_bridge_if #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16
);
  logic [31:0]               memory_addr;
  logic                      memory_rden;
  logic                      memory_wren;
  logic [31:0]               memory_write_val;
  logic [31:0]               memory_read_val;
  logic                      memory_response;
  logic                      busy;
  logic                      init_calib_complete;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;

  modport master (
    output memory_addr, memory_rden, memory_wren, memory_write_val,
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  memory_read_val, memory_response, busy,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    input  memory_addr, memory_rden, memory_wren, memory_write_val,
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output memory_read_val, memory_response, busy,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/mem_word_bridge.sv
// Turns each 32-bit Core read/write into a single 128-bit DDR3 app_* line command and returns
// a one-cycle response; one transaction in flight at a time, all in the controller ui_clk.
module mem_word_bridge #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  mem_word_bridge_if.slave bus
);

  localparam int unsigned Lanes    = APP_DATA_WIDTH / 32;
  localparam logic [2:0]  CmdWrite = 3'b000;
  localparam logic [2:0]  CmdRead  = 3'b001;

  typedef enum logic [2:0] {
    StInit, StIdle, StRdCmd, StRdWait, StWrCmd, StResp, StDrain
  } state_t;

  state_t                    r_state;
  logic                      r_busy;
  logic [31:0]               r_read_val;
  logic                      r_resp;
  logic [1:0]                r_lane;
  logic [ADDR_WIDTH-1:0]     r_app_addr;
  logic [2:0]                r_app_cmd;
  logic                      r_app_en;
  logic [APP_DATA_WIDTH-1:0] r_wdf_data;
  logic [APP_MASK_WIDTH-1:0] r_wdf_mask;
  logic                      r_wdf_wren;

  logic [1:0]                w_lane;
  logic [ADDR_WIDTH-1:0]     w_line_addr;
  logic [APP_DATA_WIDTH-1:0] w_wr_line;
  logic [APP_MASK_WIDTH-1:0] w_wr_mask;
  logic [31:0]               w_rd_word;
  logic                      w_en_hold;
  logic                      w_wren_hold;
  logic                      w_unused_addr;

  assign w_lane      = bus.memory_addr[3:2];
  // Line address in 16-bit column units: 8 columns per 128-bit line.
  assign w_line_addr = {bus.memory_addr[ADDR_WIDTH:4], 3'b000};
  assign w_wr_line   = {Lanes{bus.memory_write_val}};
  assign w_wr_mask   = ~({{(APP_MASK_WIDTH-4){1'b0}}, 4'hF} << {w_lane, 2'b00});
  assign w_rd_word   = bus.app_rd_data[{r_lane, 5'd0} +: 32];
  assign w_unused_addr = ^{bus.memory_addr[31:ADDR_WIDTH+1], bus.memory_addr[1:0]};

  // Command and write-data channels are accepted independently.
  assign w_en_hold   = r_app_en & ~bus.app_rdy;
  assign w_wren_hold = r_wdf_wren & ~bus.app_wdf_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StInit;
      r_busy     <= 1'b1;
      r_read_val <= '0;
      r_resp     <= 1'b0;
      r_lane     <= '0;
      r_app_addr <= '0;
      r_app_cmd  <= CmdWrite;
      r_app_en   <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_mask <= '1;
      r_wdf_wren <= 1'b0;
    end else begin
      unique case (r_state)
        StInit: begin
          if (bus.init_calib_complete) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StIdle: begin
          if (bus.memory_wren) begin
            r_state    <= StWrCmd;
            r_busy     <= 1'b1;
            r_lane     <= w_lane;
            r_app_addr <= w_line_addr;
            r_app_cmd  <= CmdWrite;
            r_app_en   <= 1'b1;
            r_wdf_wren <= 1'b1;
            r_wdf_data <= w_wr_line;
            r_wdf_mask <= w_wr_mask;
          end else if (bus.memory_rden) begin
            r_state    <= StRdCmd;
            r_busy     <= 1'b1;
            r_lane     <= w_lane;
            r_app_addr <= w_line_addr;
            r_app_cmd  <= CmdRead;
            r_app_en   <= 1'b1;
          end
        end
        StRdCmd: begin
          if (bus.app_rdy) begin
            r_app_en <= 1'b0;
            r_state  <= StRdWait;
          end
        end
        StRdWait: begin
          if (bus.app_rd_data_valid) begin
            r_read_val <= w_rd_word;
            r_resp     <= 1'b1;
            r_state    <= StResp;
          end
        end
        StWrCmd: begin
          r_app_en   <= w_en_hold;
          r_wdf_wren <= w_wren_hold;
          if (!w_en_hold && !w_wren_hold) begin
            r_resp  <= 1'b1;
            r_state <= StResp;
          end
        end
        StResp: begin
          r_resp  <= 1'b0;
          r_state <= StDrain;
        end
        StDrain: begin
          // Wait for the Core to drop its level request so it is not issued twice.
          if (!bus.memory_rden && !bus.memory_wren) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StInit;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.memory_read_val = r_read_val;
  assign bus.memory_response = r_resp;
  assign bus.busy            = r_busy;
  assign bus.app_addr        = r_app_addr;
  assign bus.app_cmd         = r_app_cmd;
  assign bus.app_en          = r_app_en;
  assign bus.app_wdf_data    = r_wdf_data;
  assign bus.app_wdf_mask    = r_wdf_mask;
  assign bus.app_wdf_wren    = r_wdf_wren;
  assign bus.app_wdf_end     = 1'b1;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge: a vector table of single transactions plus hand-written
// sequences for init, channel stalls, held requests, stray read data and reset mid-read.
module tb_mem_word_bridge;

  logic clk;
  logic reset;

  mem_word_bridge_if #(.ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)) bus_if ();

  mem_word_bridge #(
    .ADDR_WIDTH    (28),
    .APP_DATA_WIDTH(128),
    .APP_MASK_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] line;
    int           delay;
    logic [27:0]  exp_addr;
    logic [15:0]  exp_mask;
    logic [31:0]  exp_val;
  } vec_t;

  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bus_if.memory_addr      = v.addr;
    bus_if.memory_write_val = v.wdata;
    bus_if.memory_wren      = v.is_wr;
    bus_if.memory_rden      = !v.is_wr;
    bus_if.app_rdy          = 1'b1;
    bus_if.app_wdf_rdy      = 1'b1;
    tick();
    // Scramble Core inputs: the latched request must not change.
    bus_if.memory_wren      = 1'b0;
    bus_if.memory_rden      = 1'b0;
    bus_if.memory_addr      = 32'hFFFF_FFFF;
    bus_if.memory_write_val = 32'h0;
    check("app_en_up", bus_if.app_en, 1);
    check("app_cmd", bus_if.app_cmd, v.is_wr ? 3'b000 : 3'b001);
    check("app_addr", bus_if.app_addr, v.exp_addr);
    check("busy_txn", bus_if.busy, 1);
    if (v.is_wr) begin
      check("wdf_wren_up", bus_if.app_wdf_wren, 1);
      check("wdf_data", bus_if.app_wdf_data, {4{v.wdata}});
      check("wdf_mask", bus_if.app_wdf_mask, v.exp_mask);
      tick();
      check("wr_resp", bus_if.memory_response, 1);
      check("wr_en_down", bus_if.app_en, 0);
      check("wr_wren_down", bus_if.app_wdf_wren, 0);
    end else begin
      check("rd_wren_low", bus_if.app_wdf_wren, 0);
      tick();
      check("rd_en_down", bus_if.app_en, 0);
      check("rd_no_early_resp", bus_if.memory_response, 0);
      repeat (v.delay) tick();
      bus_if.app_rd_data       = v.line;
      bus_if.app_rd_data_valid = 1'b1;
      tick();
      bus_if.app_rd_data_valid = 1'b0;
      bus_if.app_rd_data       = '0;
      check("rd_resp", bus_if.memory_response, 1);
      check("rd_val", bus_if.memory_read_val, v.exp_val);
    end
    tick();
    check("resp_pulse_end", bus_if.memory_response, 0);
    tick();
    check("busy_idle", bus_if.busy, 0);
  endtask

  initial begin
    int   en_seen;
    int   busy_low;
    int   issues;
    int   resp_cnt;

    vecs[0] = '{1'b1, 32'h0000_0018, 32'hCAFE_F00D, 128'h0, 0, 28'h000_0008, 16'hF0FF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_000C, 32'h0,
                128'hCAFECAFE_FACEFACE_BABEBABE_BEADBEAD, 7, 28'h000_0000, 16'hFFFF, 32'hCAFE_CAFE};
    vecs[2] = '{1'b1, 32'h1234_5670, 32'h1122_3344, 128'h0, 0, 28'h91A_2B38, 16'hFFF0, 32'h0};
    vecs[3] = '{1'b0, 32'hF000_0024, 32'h0,
                128'h44444444_33333333_22222222_11111111, 0, 28'h800_0010, 16'hFFFF, 32'h2222_2222};
    vecs[4] = '{1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 128'h0, 0, 28'hFFF_FFF8, 16'h0FFF, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0008, 32'h0,
                128'h0BAD0BAD_600DF00D_12345678_9ABCDEF0, 2, 28'h000_0000, 16'hFFFF, 32'h600D_F00D};

    reset                      = 1'b1;
    bus_if.memory_addr         = '0;
    bus_if.memory_rden         = 1'b0;
    bus_if.memory_wren         = 1'b0;
    bus_if.memory_write_val    = '0;
    bus_if.init_calib_complete = 1'b0;
    bus_if.app_rdy             = 1'b1;
    bus_if.app_wdf_rdy         = 1'b1;
    bus_if.app_rd_data         = '0;
    bus_if.app_rd_data_valid   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_busy", bus_if.busy, 1);
    check("rst_app_en", bus_if.app_en, 0);
    check("rst_wdf_wren", bus_if.app_wdf_wren, 0);
    check("rst_mask", bus_if.app_wdf_mask, 16'hFFFF);
    check("rst_wdf_data", bus_if.app_wdf_data, 0);
    check("rst_app_addr", bus_if.app_addr, 0);
    check("rst_app_cmd", bus_if.app_cmd, 0);
    check("rst_resp", bus_if.memory_response, 0);
    check("rst_read_val", bus_if.memory_read_val, 0);
    check("wdf_end", bus_if.app_wdf_end, 1);

    // Requests during calibration are ignored
    bus_if.memory_rden = 1'b1;
    bus_if.memory_wren = 1'b1;
    en_seen  = 0;
    busy_low = 0;
    repeat (20) begin
      tick();
      en_seen  += int'(bus_if.app_en | bus_if.app_wdf_wren);
      busy_low += int'(!bus_if.busy);
    end
    check("init_no_cmd", en_seen, 0);
    check("init_busy_held", busy_low, 0);
    bus_if.memory_rden         = 1'b0;
    bus_if.memory_wren         = 1'b0;
    bus_if.init_calib_complete = 1'b1;
    tick();
    check("calib_idle_busy", bus_if.busy, 0);
    check("calib_no_cmd", bus_if.app_en, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Write with app_rdy low for 3 cycles and app_wdf_rdy low for 5 cycles
    bus_if.memory_addr      = 32'h0000_0004;
    bus_if.memory_write_val = 32'hA5A5_0F0F;
    bus_if.memory_wren      = 1'b1;
    bus_if.app_rdy          = 1'b0;
    bus_if.app_wdf_rdy      = 1'b0;
    tick();
    bus_if.memory_wren = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("stall_en", bus_if.app_en, (i <= 4) ? 1 : 0);
      check("stall_wren", bus_if.app_wdf_wren, (i <= 6) ? 1 : 0);
      check("stall_resp", bus_if.memory_response, (i == 7) ? 1 : 0);
      if (bus_if.app_en || bus_if.app_wdf_wren) begin
        check("stall_addr", bus_if.app_addr, 0);
        check("stall_mask", bus_if.app_wdf_mask, 16'hFF0F);
        check("stall_data", bus_if.app_wdf_data, {4{32'hA5A5_0F0F}});
      end
      bus_if.app_rdy     = (i >= 4);
      bus_if.app_wdf_rdy = (i >= 6);
      tick();
    end
    check("stall_idle", bus_if.busy, 0);

    // Read request held long after its response: issued exactly once
    bus_if.memory_addr = 32'h0000_0010;
    bus_if.memory_rden = 1'b1;
    issues   = 0;
    resp_cnt = 0;
    tick();
    issues += int'(bus_if.app_en);
    tick();
    issues += int'(bus_if.app_en);
    bus_if.app_rd_data       = 128'h0;
    bus_if.app_rd_data[31:0] = 32'h5EED_1234;
    bus_if.app_rd_data_valid = 1'b1;
    tick();
    bus_if.app_rd_data_valid = 1'b0;
    resp_cnt += int'(bus_if.memory_response);
    repeat (10) begin
      tick();
      issues   += int'(bus_if.app_en);
      resp_cnt += int'(bus_if.memory_response);
    end
    check("held_busy", bus_if.busy, 1);
    bus_if.memory_rden = 1'b0;
    tick();
    tick();
    check("held_single_issue", issues, 1);
    check("held_single_resp", resp_cnt, 1);
    check("held_val", bus_if.memory_read_val, 32'h5EED_1234);
    check("held_idle", bus_if.busy, 0);

    // Stray read data while idle
    bus_if.app_rd_data       = {4{32'hBAD0_BAD0}};
    bus_if.app_rd_data_valid = 1'b1;
    tick();
    bus_if.app_rd_data_valid = 1'b0;
    check("stray_resp", bus_if.memory_response, 0);
    tick();
    check("stray_val", bus_if.memory_read_val, 32'h5EED_1234);

    // Reset while waiting for read data; late data must be discarded
    bus_if.memory_addr = 32'h0000_0008;
    bus_if.memory_rden = 1'b1;
    tick();
    bus_if.memory_rden = 1'b0;
    tick();
    check("rw_en_down", bus_if.app_en, 0);
    reset                      = 1'b1;
    bus_if.init_calib_complete = 1'b0;
    tick();
    reset = 1'b0;
    check("rw_busy", bus_if.busy, 1);
    check("rw_read_val", bus_if.memory_read_val, 0);
    check("rw_app_en", bus_if.app_en, 0);
    bus_if.app_rd_data       = {4{32'h7777_7777}};
    bus_if.app_rd_data_valid = 1'b1;
    tick();
    bus_if.app_rd_data_valid = 1'b0;
    resp_cnt = int'(bus_if.memory_response);
    repeat (3) begin
      tick();
      resp_cnt += int'(bus_if.memory_response);
    end
    check("rw_no_resp", resp_cnt, 0);
    check("rw_val_zero", bus_if.memory_read_val, 0);
    check("rw_still_init", bus_if.busy, 1);
    bus_if.init_calib_complete = 1'b1;
    tick();
    check("rw_recover_idle", bus_if.busy, 0);
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
